// File: rtl/recirc_return_merger.sv
// Return-path merger for the 4-lane recirculator.
// Buffers recirculated words per lane and merges them with fresh source words
// into one registered 4-lane stream. Recirculated words have priority over fresh words.
module recirc_return_merger #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_1,
   input  logic             reset,
   input  logic             active,
   input  logic [WIDTH-1:0] rc_data0,
   input  logic [WIDTH-1:0] rc_data1,
   input  logic [WIDTH-1:0] rc_data2,
   input  logic [WIDTH-1:0] rc_data3,
   input  logic             rc_valid0,
   input  logic             rc_valid1,
   input  logic             rc_valid2,
   input  logic             rc_valid3,
   input  logic [WIDTH-1:0] src_data0,
   input  logic [WIDTH-1:0] src_data1,
   input  logic [WIDTH-1:0] src_data2,
   input  logic [WIDTH-1:0] src_data3,
   input  logic             src_valid0,
   input  logic             src_valid1,
   input  logic             src_valid2,
   input  logic             src_valid3,
   output logic             src_ready,
   output logic [WIDTH-1:0] dataOut0,
   output logic [WIDTH-1:0] dataOut1,
   output logic [WIDTH-1:0] dataOut2,
   output logic [WIDTH-1:0] dataOut3,
   output logic             validOut0,
   output logic             validOut1,
   output logic             validOut2,
   output logic             validOut3,
   output logic [3:0]       overflow,
   output logic [2:0]       pending
);

   localparam int unsigned LANES = 4;
   localparam int unsigned PTRW  = $clog2(DEPTH);
   localparam int unsigned CNTW  = PTRW + 1;
   localparam int unsigned SUMW  = CNTW + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } stateType;

   stateType state;
   stateType stateNext;

   logic [WIDTH-1:0] rcData   [LANES];
   logic [WIDTH-1:0] srcData  [LANES];
   logic [WIDTH-1:0] outData  [LANES];
   logic [WIDTH-1:0] fifoMem  [LANES][DEPTH];
   logic [PTRW-1:0]  rdPtr    [LANES];
   logic [PTRW-1:0]  wrPtr    [LANES];
   logic [CNTW-1:0]  count    [LANES];
   logic [CNTW-1:0]  countNext[LANES];

   logic [LANES-1:0] rcValid;
   logic [LANES-1:0] srcValid;
   logic [LANES-1:0] outValid;
   logic [LANES-1:0] fifoFull;
   logic [LANES-1:0] doPop;
   logic [LANES-1:0] doPush;
   logic [LANES-1:0] doDrop;
   logic             anyRc;
   logic             anyBuffered;
   logic             allEmptyNext;
   logic             srcReadyC;
   logic [SUMW-1:0]  pendingSum;

   // Flatten the per-lane ports into arrays
   assign rcData[0]  = rc_data0;
   assign rcData[1]  = rc_data1;
   assign rcData[2]  = rc_data2;
   assign rcData[3]  = rc_data3;
   assign srcData[0] = src_data0;
   assign srcData[1] = src_data1;
   assign srcData[2] = src_data2;
   assign srcData[3] = src_data3;
   assign rcValid    = {rc_valid3, rc_valid2, rc_valid1, rc_valid0};
   assign srcValid   = {src_valid3, src_valid2, src_valid1, src_valid0};

   assign dataOut0   = outData[0];
   assign dataOut1   = outData[1];
   assign dataOut2   = outData[2];
   assign dataOut3   = outData[3];
   assign validOut0  = outValid[0];
   assign validOut1  = outValid[1];
   assign validOut2  = outValid[2];
   assign validOut3  = outValid[3];
   assign src_ready  = srcReadyC;

   // State register
   always_ff @(posedge clk_1) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // FIFO control, next state and source handshake
   always_comb begin
      stateNext    = state;
      srcReadyC    = 1'b0;
      doPop        = '0;
      doPush       = '0;
      doDrop       = '0;
      fifoFull     = '0;
      anyRc        = |rcValid;
      anyBuffered  = 1'b0;
      allEmptyNext = 1'b1;
      pendingSum   = '0;

      for (int i = 0; i < int'(LANES); i++) begin
         fifoFull[i]  = (count[i] == CNTW'(DEPTH));
         doPop[i]     = (state == DRAIN) && (count[i] != '0);
         doPush[i]    = rcValid[i] && (!fifoFull[i] || doPop[i]);
         doDrop[i]    = rcValid[i] && fifoFull[i] && !doPop[i];
         countNext[i] = count[i] + CNTW'(doPush[i]) - CNTW'(doPop[i]);
         if (count[i] != '0) begin
            anyBuffered = 1'b1;
         end
         if (countNext[i] != '0) begin
            allEmptyNext = 1'b0;
         end
         pendingSum = pendingSum + SUMW'(countNext[i]);
      end

      case (state)
         IDLE: begin
            // A word arriving on the leaving edge also counts as buffered, so PASS
            // is only ever entered with every FIFO empty.
            if (active) begin
               stateNext = (anyBuffered || anyRc) ? DRAIN : PASS;
            end
         end
         PASS: begin
            srcReadyC = !anyRc;
            if (anyRc) begin
               stateNext = DRAIN;
            end else if (!active) begin
               stateNext = IDLE;
            end
         end
         DRAIN: begin
            // active is only looked at once the drain completes; a deasserted
            // active goes straight to IDLE so the source is never offered a slot.
            if (allEmptyNext && !anyRc) begin
               stateNext = active ? PASS : IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // FIFO pointers, occupancy, sticky overflow and pending total
   always_ff @(posedge clk_1) begin
      if (reset) begin
         for (int i = 0; i < int'(LANES); i++) begin
            rdPtr[i] <= '0;
            wrPtr[i] <= '0;
            count[i] <= '0;
         end
         overflow <= '0;
         pending  <= '0;
      end else begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (doPush[i]) begin
               wrPtr[i] <= wrPtr[i] + 1'b1;
            end
            if (doPop[i]) begin
               rdPtr[i] <= rdPtr[i] + 1'b1;
            end
            count[i] <= countNext[i];
            if (doDrop[i]) begin
               overflow[i] <= 1'b1;
            end
         end
         pending <= (pendingSum > SUMW'(7)) ? 3'd7 : pendingSum[2:0];
      end
   end

   // FIFO storage; contents need no reset
   always_ff @(posedge clk_1) begin
      for (int i = 0; i < int'(LANES); i++) begin
         if (doPush[i]) begin
            fifoMem[i][wrPtr[i]] <= rcData[i];
         end
      end
   end

   // Merged output register: FIFO heads in DRAIN, fresh words in PASS
   always_ff @(posedge clk_1) begin
      if (reset) begin
         for (int i = 0; i < int'(LANES); i++) begin
            outData[i] <= '0;
         end
         outValid <= '0;
      end else begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (state == DRAIN) begin
               if (doPop[i]) begin
                  outData[i]  <= fifoMem[i][rdPtr[i]];
                  outValid[i] <= 1'b1;
               end else begin
                  outValid[i] <= 1'b0;
               end
            end else if (srcReadyC) begin
               outData[i]  <= srcData[i];
               outValid[i] <= srcValid[i];
            end else begin
               outValid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_recirc_return_merger.sv
// Scoreboard bench for recirc_return_merger: a queue-based reference model predicts
// each edge's outputs; a monitor compares them one edge later.
module tb_recirc_return_merger;

   localparam int DEPTH   = 4;
   localparam int M_IDLE  = 0;
   localparam int M_PASS  = 1;
   localparam int M_DRAIN = 2;

   typedef struct packed {
      logic [3:0]  v;
      logic [31:0] d;
      logic [2:0]  pend;
      logic [3:0]  ovf;
   } statusT;

   logic       clk_1;
   logic       reset;
   logic       active;
   logic [7:0] rc_data0, rc_data1, rc_data2, rc_data3;
   logic       rc_valid0, rc_valid1, rc_valid2, rc_valid3;
   logic [7:0] src_data0, src_data1, src_data2, src_data3;
   logic       src_valid0, src_valid1, src_valid2, src_valid3;
   logic       src_ready;
   logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
   logic       validOut0, validOut1, validOut2, validOut3;
   logic [3:0] overflow;
   logic [2:0] pending;

   logic [3:0]  vOut;
   logic [31:0] dOut;
   assign vOut = {validOut3, validOut2, validOut1, validOut0};
   assign dOut = {dataOut3, dataOut2, dataOut1, dataOut0};

   int nVectors     = 0;
   int nMiscompares = 0;

   // reference model state
   int         mMode = M_IDLE;
   bit         mInit = 1'b0;
   logic [7:0] mq[4][$];
   logic [7:0] mOutD[4];
   logic [3:0] mOutV;
   logic [3:0] mOvf;

   // scoreboard queues
   statusT     statQ[$];
   logic [7:0] dataQ[4][$];

   recirc_return_merger #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk_1(clk_1), .reset(reset), .active(active),
      .rc_data0(rc_data0), .rc_data1(rc_data1), .rc_data2(rc_data2), .rc_data3(rc_data3),
      .rc_valid0(rc_valid0), .rc_valid1(rc_valid1), .rc_valid2(rc_valid2), .rc_valid3(rc_valid3),
      .src_data0(src_data0), .src_data1(src_data1), .src_data2(src_data2), .src_data3(src_data3),
      .src_valid0(src_valid0), .src_valid1(src_valid1), .src_valid2(src_valid2), .src_valid3(src_valid3),
      .src_ready(src_ready),
      .dataOut0(dataOut0), .dataOut1(dataOut1), .dataOut2(dataOut2), .dataOut3(dataOut3),
      .validOut0(validOut0), .validOut1(validOut1), .validOut2(validOut2), .validOut3(validOut3),
      .overflow(overflow), .pending(pending)
   );

   initial clk_1 = 1'b0;
   always #5 clk_1 = ~clk_1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle (called at posedge+2), predict that edge's result, return at next posedge+2
   task automatic drive_cycle(input logic r, input logic a, input logic [3:0] rv, input logic [31:0] rd,
                              input logic [3:0] sv, input logic [31:0] sd);
      statusT e;
      bit     passReady;
      bit     popped;
      bit     allEmpty;
      int     sz;
      int     total;
      reset = r;
      active = a;
      {rc_valid3, rc_valid2, rc_valid1, rc_valid0} = rv;
      {rc_data3, rc_data2, rc_data1, rc_data0}     = rd;
      {src_valid3, src_valid2, src_valid1, src_valid0} = sv;
      {src_data3, src_data2, src_data1, src_data0}     = sd;
      #1;
      passReady = (mMode == M_PASS) && (rv == 4'h0);
      if (mInit) chk("src_ready", 32'(src_ready), 32'(passReady));
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            mOutD[i] = 8'h00;
         end
         mOutV = 4'h0;
         mOvf  = 4'h0;
         mMode = M_IDLE;
         mInit = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            sz     = mq[i].size();
            popped = (mMode == M_DRAIN) && (sz > 0);
            if (popped) begin
               mOutD[i] = mq[i].pop_front();
               mOutV[i] = 1'b1;
            end else if (passReady) begin
               mOutD[i] = sd[8*i +: 8];
               mOutV[i] = sv[i];
            end else begin
               mOutV[i] = 1'b0;
            end
            if (rv[i]) begin
               if (sz == DEPTH && !popped) mOvf[i] = 1'b1;
               else mq[i].push_back(rd[8*i +: 8]);
            end
         end
         allEmpty = 1'b1;
         for (int i = 0; i < 4; i++) if (mq[i].size() != 0) allEmpty = 1'b0;
         case (mMode)
            M_IDLE:  if (a) mMode = allEmpty ? M_PASS : M_DRAIN;
            M_PASS:  if (rv != 4'h0) mMode = M_DRAIN; else if (!a) mMode = M_IDLE;
            default: if (allEmpty) mMode = a ? M_PASS : M_IDLE;
         endcase
      end
      total = 0;
      for (int i = 0; i < 4; i++) total += mq[i].size();
      e.v    = mOutV;
      e.d    = {mOutD[3], mOutD[2], mOutD[1], mOutD[0]};
      e.pend = 3'((total > 7) ? 7 : total);
      e.ovf  = mOvf;
      statQ.push_back(e);
      for (int i = 0; i < 4; i++) if (mOutV[i]) dataQ[i].push_back(mOutD[i]);
      @(posedge clk_1);
      #2;
   endtask

   // Monitor: after every edge, compare registered outputs with the prediction
   initial begin
      statusT e;
      logic [7:0] exp;
      forever begin
         @(posedge clk_1);
         #1;
         if (statQ.size() > 0) begin
            e = statQ.pop_front();
            chk("validOut", 32'(vOut), 32'(e.v));
            chk("dataOut", dOut, e.d);
            chk("pending", 32'(pending), 32'(e.pend));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            for (int i = 0; i < 4; i++) begin
               if (vOut[i]) begin
                  if (dataQ[i].size() == 0) begin
                     chk($sformatf("lane%0d_unexpected_word", i), 32'(dOut[8*i +: 8]), 32'hFFFF_FFFF);
                  end else begin
                     exp = dataQ[i].pop_front();
                     chk($sformatf("lane%0d_word", i), 32'(dOut[8*i +: 8]), 32'(exp));
                  end
               end
            end
         end
      end
   end

   initial begin
      logic       act;
      logic [3:0] rv;
      int         p;
      @(posedge clk_1);
      #2;

      // T1: reset then fresh words forwarded in PASS
      drive_cycle(1, 0, 4'h0, 32'h0, 4'h0, 32'h0);
      chk("reset_valid", 32'(vOut), 32'h0);
      chk("reset_pending", 32'(pending), 32'h0);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'hF, 32'hCCDD_EEFF);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'hF, 32'hCCDD_EEFF);
      chk("t1_valid", 32'(vOut), 32'hF);
      chk("t1_data", dOut, 32'hCCDD_EEFF);

      // T2: single recirculated word on lane 2
      drive_cycle(0, 1, 4'b0100, 32'h0077_0000, 4'hF, 32'h1234_5678);
      chk("t2_pending", 32'(pending), 32'd1);
      chk("t2_no_valid", 32'(vOut), 32'h0);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'hF, 32'h1234_5678);
      chk("t2_lane2_valid", 32'(vOut), 32'b0100);
      chk("t2_lane2_data", 32'(dataOut2), 32'h77);
      chk("t2_back_to_pass", 32'(src_ready), 32'h1);

      // T3: back-to-back recirculation on lane 0 while draining
      for (int k = 0; k < 6; k++) drive_cycle(0, 1, 4'b0001, 32'(8'h11 + k), 4'h0, 32'h0);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'h0, 32'h0);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'h0, 32'h0);
      chk("t3_overflow", 32'(overflow), 32'h0);

      // T4: overflow lane 1 while idle, then drain
      drive_cycle(0, 0, 4'h0, 32'h0, 4'h0, 32'h0);
      for (int k = 0; k < 5; k++) drive_cycle(0, 0, 4'b0010, 32'(8'h21 + k) << 8, 4'h0, 32'h0);
      chk("t4_overflow", 32'(overflow), 32'b0010);
      chk("t4_pending", 32'(pending), 32'd4);
      for (int k = 0; k < 6; k++) drive_cycle(0, 1, 4'h0, 32'h0, 4'h0, 32'h0);
      chk("t4_drained", 32'(pending), 32'd0);

      // T5: reset during DRAIN with three words buffered
      drive_cycle(0, 0, 4'h0, 32'h0, 4'h0, 32'h0);
      drive_cycle(0, 0, 4'b1011, 32'h3300_3231, 4'h0, 32'h0);
      chk("t5_pending_idle", 32'(pending), 32'd3);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'h0, 32'h0);
      chk("t5_pending_drain", 32'(pending), 32'd3);
      drive_cycle(1, 1, 4'h0, 32'h0, 4'hF, 32'hFFFF_FFFF);
      chk("t5_valid", 32'(vOut), 32'h0);
      chk("t5_pending", 32'(pending), 32'h0);
      chk("t5_overflow", 32'(overflow), 32'h0);
      chk("t5_src_ready", 32'(src_ready), 32'h0);

      // T6: active dropped mid-drain; everything still drains, then IDLE
      drive_cycle(0, 0, 4'b0101, 32'h00A2_00A1, 4'h0, 32'h0);
      drive_cycle(0, 0, 4'b0101, 32'h00B2_00B1, 4'h0, 32'h0);
      drive_cycle(0, 0, 4'b0001, 32'h0000_00C1, 4'h0, 32'h0);
      drive_cycle(0, 1, 4'h0, 32'h0, 4'hF, $urandom);
      for (int k = 0; k < 5; k++) begin
         drive_cycle(0, 0, 4'h0, 32'h0, 4'hF, $urandom);
         chk("t6_src_ready", 32'(src_ready), 32'h0);
      end
      chk("t6_pending", 32'(pending), 32'h0);

      // Randomized traffic
      act = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 19) == 0) act = ~act;
         p = ((n / 250) % 2 == 1) ? 3 : 10;
         for (int i = 0; i < 4; i++) rv[i] = ($urandom_range(0, p - 1) == 0);
         drive_cycle(($urandom_range(0, 299) == 0), act, rv, $urandom, 4'($urandom), $urandom);
      end
      drive_cycle(0, 0, 4'h0, 32'h0, 4'h0, 32'h0);
      drive_cycle(0, 0, 4'h0, 32'h0, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) chk($sformatf("lane%0d_words_outstanding", i), 32'(dataQ[i].size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
